fifo_patch_reader: RTL

Read side of the 11-bit input FIFO. Drains pixel words from a first-word-fall-through FIFO, assembles `WORDS_PER_PATCH` consecutive words into one patch vector, and presents each patch to the downstream matching datapath over a valid/ready handshake. After `NUM_PATCHES` patches it reports `done`. It is the consumer counterpart of the I/O writer that fills the FIFO.

---
 rtl/fifo_patch_reader_pkg.sv | 21 ++
 rtl/fifo_patch_reader_if.sv | 31 +++
 rtl/fifo_patch_reader_patch_assembler.sv | 35 +++
 rtl/fifo_patch_reader.sv | 95 +++++++++
 4 files changed

// File: rtl/fifo_patch_reader_pkg.sv
// Shared constants for the FIFO patch reader: FSM encoding, default sizes and
// counter-width helper.
package fifo_patch_reader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t FILL = 2'd1;
  localparam state_t HOLD = 2'd2;
  localparam state_t DONE = 2'd3;

  localparam int DEF_DATA_WIDTH      = 11;
  localparam int DEF_WORDS_PER_PATCH = 5;
  localparam int DEF_NUM_PATCHES     = 16;

  // Width of a counter indexing n items; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_patch_reader_if.sv
// FIFO read port plus patch valid/ready channel. The reader uses the master
// modport; the FIFO/downstream side uses slave.
interface fifo_patch_reader_if
  import fifo_patch_reader_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int WORDS_PER_PATCH = DEF_WORDS_PER_PATCH,
  parameter int NUM_PATCHES     = DEF_NUM_PATCHES
);
  localparam int IDX_W = cnt_w(NUM_PATCHES);

  logic [DATA_WIDTH-1:0]                 fifo_dout;
  logic                                  fifo_empty_n;
  logic                                  fifo_deq;
  logic                                  fifo_clr;
  logic [DATA_WIDTH*WORDS_PER_PATCH-1:0] patch_data;
  logic                                  patch_valid;
  logic                                  patch_ready;
  logic [IDX_W-1:0]                      patch_idx;

  modport master (
    input  fifo_dout, fifo_empty_n, patch_ready,
    output fifo_deq, fifo_clr, patch_data, patch_valid, patch_idx
  );

  modport slave (
    output fifo_dout, fifo_empty_n, patch_ready,
    input  fifo_deq, fifo_clr, patch_data, patch_valid, patch_idx
  );

endinterface

// File: rtl/fifo_patch_reader_patch_assembler.sv
// Slot-indexed register bank that collects FIFO words into one flat patch
// vector, slot 0 in the LSBs.
module patch_assembler #(
  parameter int DATA_WIDTH      = 11,
  parameter int WORDS_PER_PATCH = 5,
  parameter int IDX_W           = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_en,
  input  logic [IDX_W-1:0]                      wr_idx,
  input  logic [DATA_WIDTH-1:0]                 wr_data,
  output logic [DATA_WIDTH*WORDS_PER_PATCH-1:0] patch_data
);

  logic [DATA_WIDTH-1:0] slots [WORDS_PER_PATCH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WORDS_PER_PATCH; i++) slots[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < WORDS_PER_PATCH; i++) begin
        if (wr_idx == IDX_W'(i)) slots[i] <= wr_data;
      end
    end
  end

  always_comb begin
    patch_data = '0;
    for (int i = 0; i < WORDS_PER_PATCH; i++) begin
      patch_data[i*DATA_WIDTH +: DATA_WIDTH] = slots[i];
    end
  end

endmodule

// File: rtl/fifo_patch_reader.sv
// Drains a FWFT FIFO into WORDS_PER_PATCH-word patches, hands each patch off
// over valid/ready and raises done after NUM_PATCHES patches.
module fifo_patch_reader
  import fifo_patch_reader_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int WORDS_PER_PATCH = DEF_WORDS_PER_PATCH,
  parameter int NUM_PATCHES     = DEF_NUM_PATCHES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 done,
  fifo_patch_reader_if.master  bus
);

  localparam int WC_W  = cnt_w(WORDS_PER_PATCH);
  localparam int IDX_W = cnt_w(NUM_PATCHES);
  localparam logic [WC_W-1:0]  LAST_WORD  = WC_W'(WORDS_PER_PATCH - 1);
  localparam logic [IDX_W-1:0] LAST_PATCH = IDX_W'(NUM_PATCHES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WC_W-1:0]  word_cnt;
  logic [IDX_W-1:0] idx_q;
  logic             clr_q;
  logic             begin_run;
  logic             accept;

  assign begin_run = ((state_q == IDLE) || (state_q == DONE)) && start && !abort;
  assign accept    = (state_q == HOLD) && bus.patch_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // abort overrides every transition, including a simultaneous start
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) state_d = FILL;
        FILL:       if (bus.fifo_deq && (word_cnt == LAST_WORD)) state_d = HOLD;
        HOLD:       if (bus.patch_ready) state_d = (idx_q == LAST_PATCH) ? DONE : FILL;
        default:    state_d = IDLE;
      endcase
    end
  end

  // fifo_deq is the only combinational output: it must never pop an empty FIFO
  always_comb begin
    bus.fifo_deq    = (state_q == FILL) && bus.fifo_empty_n && !abort;
    bus.patch_valid = (state_q == HOLD);
    done            = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      word_cnt <= '0;
      idx_q    <= '0;
    end else if (begin_run) begin
      word_cnt <= '0;
      idx_q    <= '0;
    end else begin
      if (bus.fifo_deq) word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
      if (accept && (idx_q != LAST_PATCH)) idx_q <= idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) clr_q <= 1'b0;
    else     clr_q <= abort;
  end

  assign bus.fifo_clr  = clr_q;
  assign bus.patch_idx = idx_q;

  patch_assembler #(
    .DATA_WIDTH      (DATA_WIDTH),
    .WORDS_PER_PATCH (WORDS_PER_PATCH),
    .IDX_W           (WC_W)
  ) u_assembler (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (bus.fifo_deq),
    .wr_idx     (word_cnt),
    .wr_data    (bus.fifo_dout),
    .patch_data (bus.patch_data)
  );

endmodule
